frame_diff_ext: RTL and testbench

FRAME_DIFF_EXT -- requirements
Module: frame_diff_ext

---
 rtl/frame_diff_ext.sv | 191 +++++++++++++++++++
 tb/tb_frame_diff_ext.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_diff_ext.sv
// -----------------------------------------------------------------------------
// frame_diff_ext
// Per-pixel frame differencing with motion-pixel counting.
//
// A current-frame pixel and the matching previous-frame pixel arrive on the
// same cycle. Stage 1 registers the per-channel absolute difference. Stage 2
// applies the threshold and the output mode, and registers the result
// together with the delayed sync signals, so everything is 2 cycles late.
// Motion pixels are counted per frame. The count is published when post_vsync
// falls.
//
// Parameters
//   DW     bits per channel sample
//   CH     channels per pixel (1 or 3)
//   CNT_W  width of the motion-pixel counter
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   cfg_thresh [DW]               difference threshold (strict compare)
//   cfg_mode [2]                  0 thresholded diff, 1 binary mask,
//                                 2 raw |diff|, 3 same as 0
//   cur_vsync/hsync/valid         current-frame timing
//   cur_data [CH*DW]              current pixel, channel k at [k*DW +: DW]
//   ref_data [CH*DW]              previous-frame pixel, same alignment
//   post_vsync/hsync/valid        timing delayed by 2 cycles
//   post_data [CH*DW]             difference result
//   motion_cnt [CNT_W]            motion-pixel count of the last frame
//   motion_cnt_vld                one-cycle pulse when motion_cnt loads
// -----------------------------------------------------------------------------
module frame_diff_ext #(
  parameter int DW    = 8,
  parameter int CH    = 1,
  parameter int CNT_W = 22
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DW-1:0]       cfg_thresh,
  input  logic [1:0]          cfg_mode,
  input  logic                cur_vsync,
  input  logic                cur_hsync,
  input  logic                cur_valid,
  input  logic [CH*DW-1:0]    cur_data,
  input  logic [CH*DW-1:0]    ref_data,
  output logic                post_vsync,
  output logic                post_hsync,
  output logic                post_valid,
  output logic [CH*DW-1:0]    post_data,
  output logic [CNT_W-1:0]    motion_cnt,
  output logic                motion_cnt_vld
);

  localparam int W = CH * DW;

  // ---------------------------------------------------------------------------
  // Frame start detection and shadow configuration
  // ---------------------------------------------------------------------------
  logic          cur_vsync_d_reg;
  logic          vs_rise;
  logic [DW-1:0] thresh_sh_reg;
  logic [1:0]    mode_sh_reg;

  // The edge register resets to 0, so a frame already in progress when reset
  // is released is seen as a new frame start.
  assign vs_rise = cur_vsync & ~cur_vsync_d_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_vsync_d_reg <= 1'b0;
      thresh_sh_reg   <= '0;
      mode_sh_reg     <= 2'd0;
    end else begin
      cur_vsync_d_reg <= cur_vsync;
      // The first pixel of a frame reaches stage 2 one cycle later, so it
      // already sees the newly captured values.
      if (vs_rise) begin
        thresh_sh_reg <= cfg_thresh;
        mode_sh_reg   <= cfg_mode;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: per-channel absolute difference
  // ---------------------------------------------------------------------------
  logic [W-1:0] diff_next;
  logic [W-1:0] s1_diff_reg;
  logic         s1_vsync_reg;
  logic         s1_hsync_reg;
  logic         s1_valid_reg;

  for (genvar gi = 0; gi < CH; gi++) begin : g_diff
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    assign a = cur_data[gi*DW +: DW];
    assign b = ref_data[gi*DW +: DW];
    assign diff_next[gi*DW +: DW] = (a >= b) ? (a - b) : (b - a);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_diff_reg  <= '0;
      s1_vsync_reg <= 1'b0;
      s1_hsync_reg <= 1'b0;
      s1_valid_reg <= 1'b0;
    end else begin
      s1_diff_reg  <= diff_next;
      s1_vsync_reg <= cur_vsync;
      s1_hsync_reg <= cur_hsync;
      s1_valid_reg <= cur_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: threshold compare and output mode, decided per channel
  // ---------------------------------------------------------------------------
  logic [CH-1:0] pass;
  logic [W-1:0]  res_next;
  logic          prev_ok_reg;
  logic          pix_en;
  logic          motion_next;

  for (genvar gi = 0; gi < CH; gi++) begin : g_mode
    logic [DW-1:0] d;
    assign d        = s1_diff_reg[gi*DW +: DW];
    assign pass[gi] = (d > thresh_sh_reg);

    always_comb begin
      res_next[gi*DW +: DW] = '0;
      case (mode_sh_reg)
        2'd1:    res_next[gi*DW +: DW] = pass[gi] ? {DW{1'b1}} : {DW{1'b0}};
        2'd2:    res_next[gi*DW +: DW] = d;
        default: res_next[gi*DW +: DW] = pass[gi] ? d : {DW{1'b0}};
      endcase
    end
  end

  // Until one full frame end has been seen the reference frame is not
  // trustworthy, so results are blanked and nothing is counted.
  assign pix_en      = s1_valid_reg & prev_ok_reg;
  assign motion_next = pix_en & (|pass);

  logic post_motion_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_vsync      <= 1'b0;
      post_hsync      <= 1'b0;
      post_valid      <= 1'b0;
      post_data       <= '0;
      post_motion_reg <= 1'b0;
    end else begin
      post_vsync      <= s1_vsync_reg;
      post_hsync      <= s1_hsync_reg;
      post_valid      <= s1_valid_reg;
      post_data       <= pix_en ? res_next : '0;
      post_motion_reg <= motion_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Motion accumulation and per-frame publishing
  // ---------------------------------------------------------------------------
  logic             post_vsync_d_reg;
  logic             frame_end;
  logic [CNT_W-1:0] acc_reg;

  assign frame_end = post_vsync_d_reg & ~post_vsync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_vsync_d_reg <= 1'b0;
      acc_reg          <= '0;
      motion_cnt       <= '0;
      motion_cnt_vld   <= 1'b0;
      prev_ok_reg      <= 1'b0;
    end else begin
      post_vsync_d_reg <= post_vsync;
      motion_cnt_vld   <= frame_end;
      if (frame_end) begin
        // Clear has priority; post_valid is low outside vsync anyway.
        motion_cnt  <= acc_reg;
        acc_reg     <= '0;
        prev_ok_reg <= 1'b1;
      end else if (post_valid && post_motion_reg &&
                   (acc_reg != {CNT_W{1'b1}})) begin
        acc_reg <= acc_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_diff_ext.sv
// -----------------------------------------------------------------------------
// tb_frame_diff_ext
// Self-checking bench for frame_diff_ext (DW=8, CH=3, CNT_W=4).
// Stimulus is driven 1 time unit after each rising edge. A behavioural model
// works out, per driven cycle, what the outputs must show 2 cycles later and
// when the frame count must appear. One compare process checks every cycle on
// the falling edge. A few literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_frame_diff_ext;

  localparam int DW    = 8;
  localparam int CH    = 3;
  localparam int CNT_W = 4;
  localparam int W     = CH * DW;
  localparam int MAXC  = 8192;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DW-1:0]    cfg_thresh = '0;
  logic [1:0]       cfg_mode = 2'd0;
  logic             cur_vsync = 1'b0;
  logic             cur_hsync = 1'b0;
  logic             cur_valid = 1'b0;
  logic [W-1:0]     cur_data = '0;
  logic [W-1:0]     ref_data = '0;
  logic             post_vsync;
  logic             post_hsync;
  logic             post_valid;
  logic [W-1:0]     post_data;
  logic [CNT_W-1:0] motion_cnt;
  logic             motion_cnt_vld;

  frame_diff_ext #(.DW(DW), .CH(CH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_thresh     (cfg_thresh),
    .cfg_mode       (cfg_mode),
    .cur_vsync      (cur_vsync),
    .cur_hsync      (cur_hsync),
    .cur_valid      (cur_valid),
    .cur_data       (cur_data),
    .ref_data       (ref_data),
    .post_vsync     (post_vsync),
    .post_hsync     (post_hsync),
    .post_valid     (post_valid),
    .post_data      (post_data),
    .motion_cnt     (motion_cnt),
    .motion_cnt_vld (motion_cnt_vld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output per cycle
  bit           e_set [MAXC];
  bit           e_rst [MAXC];
  bit           e_vs  [MAXC];
  bit           e_hs  [MAXC];
  bit           e_val [MAXC];
  bit           e_vld [MAXC];
  logic [W-1:0] e_data[MAXC];
  int           e_cnt [MAXC];
  // Hand-computed literal expectations
  bit           l_dset[MAXC];
  logic [W-1:0] l_data[MAXC];
  bit           l_cset[MAXC];
  int           l_cnt [MAXC];

  // Model state
  bit        m_prev_vs = 1'b0;
  bit        m_prev_ok = 1'b0;
  int        m_th = 0;
  int        m_mode = 0;
  int        m_count = 0;

  bit           lit_d_en = 1'b0;
  logic [W-1:0] lit_d = '0;
  bit           lit_c_en = 1'b0;
  int           lit_c = 0;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [W-1:0] rep(input int v);
    logic [DW-1:0] b;
    b = v[DW-1:0];
    return {b, b, b};
  endfunction

  // Expected pixel result from the difference rules; any_pass reports motion.
  function automatic logic [W-1:0] model_pix(input logic [W-1:0] c,
                                             input logic [W-1:0] r,
                                             input int th, input int md,
                                             output bit any_pass);
    logic [W-1:0] res;
    res = '0;
    any_pass = 1'b0;
    for (int k = 0; k < CH; k++) begin
      int a, b, d, o;
      bit p;
      a = int'(c[k*DW +: DW]);
      b = int'(r[k*DW +: DW]);
      d = (a > b) ? a - b : b - a;
      p = (d > th);
      if (p) any_pass = 1'b1;
      if (md == 1)      o = p ? 255 : 0;
      else if (md == 2) o = d;
      else              o = p ? d : 0;
      res[k*DW +: DW] = o[DW-1:0];
    end
    return res;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // One driven cycle plus the model update for it.
  task automatic step(input bit vs, input bit hs, input bit val,
                      input logic [W-1:0] c, input logic [W-1:0] r);
    logic [W-1:0] d;
    bit any;
    @(posedge clk);
    #1;
    if (cyc + 3 >= MAXC) begin
      $display("FAIL cycle_budget cycle=%0d actual=%0d required=<%0d", cyc, cyc + 3, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    rst       = 1'b0;
    cur_vsync = vs;
    cur_hsync = hs;
    cur_valid = val;
    cur_data  = c;
    ref_data  = r;
    if (vs && !m_prev_vs) begin
      m_th   = int'(cfg_thresh);
      m_mode = int'(cfg_mode);
    end
    if (!vs && m_prev_vs) begin
      e_vld[cyc+3] = 1'b1;
      e_cnt[cyc+3] = m_count;
      if (lit_c_en) begin
        l_cset[cyc+3] = 1'b1;
        l_cnt[cyc+3]  = lit_c;
      end
      m_count   = 0;
      m_prev_ok = 1'b1;
    end
    d   = '0;
    any = 1'b0;
    if (val && m_prev_ok) d = model_pix(c, r, m_th, m_mode, any);
    if (any) m_count = (m_count < CMAX) ? m_count + 1 : CMAX;
    e_set[cyc+2]  = 1'b1;
    e_vs[cyc+2]   = vs;
    e_hs[cyc+2]   = hs;
    e_val[cyc+2]  = val;
    e_data[cyc+2] = d;
    if (lit_d_en) begin
      l_dset[cyc+2] = 1'b1;
      l_data[cyc+2] = lit_d;
    end
    m_prev_vs = vs;
  endtask

  task automatic do_reset(input bit vs, input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rst       = 1'b1;
      cur_vsync = vs;
      cur_hsync = 1'b0;
      cur_valid = 1'b0;
      cur_data  = '0;
      ref_data  = '0;
      for (int k = 0; k < 4; k++) begin
        e_set[cyc+k]  = 1'b1;
        e_rst[cyc+k]  = 1'b1;
        e_vs[cyc+k]   = 1'b0;
        e_hs[cyc+k]   = 1'b0;
        e_val[cyc+k]  = 1'b0;
        e_vld[cyc+k]  = 1'b0;
        e_data[cyc+k] = '0;
        l_dset[cyc+k] = 1'b0;
        l_cset[cyc+k] = 1'b0;
      end
      m_prev_vs = 1'b0;
      m_prev_ok = 1'b0;
      m_th      = 0;
      m_mode    = 0;
      m_count   = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic gap();
    step(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic frame_begin();
    gap();
    gap();
  endtask

  task automatic px(input logic [W-1:0] c, input logic [W-1:0] r);
    step(1'b1, 1'b1, 1'b1, c, r);
  endtask

  task automatic px_lit(input logic [W-1:0] c, input logic [W-1:0] r, input logic [W-1:0] d);
    lit_d_en = 1'b1;
    lit_d    = d;
    px(c, r);
    lit_d_en = 1'b0;
  endtask

  task automatic frame_end(input bit lit_en, input int lit);
    gap();
    lit_c_en = lit_en;
    lit_c    = lit;
    step(1'b0, 1'b0, 1'b0, '0, '0);
    lit_c_en = 1'b0;
    idle(5);
  endtask

  // Compare process
  int mc_exp = 0;
  always @(negedge clk) begin
    if (cyc < MAXC && e_set[cyc]) begin
      if (e_rst[cyc]) mc_exp = 0;
      if (e_vld[cyc]) mc_exp = e_cnt[cyc];
      chk("post_vsync", 32'(post_vsync), 32'(e_vs[cyc]));
      chk("post_hsync", 32'(post_hsync), 32'(e_hs[cyc]));
      chk("post_valid", 32'(post_valid), 32'(e_val[cyc]));
      chk("post_data", 32'(post_data), 32'(e_data[cyc]));
      chk("motion_cnt_vld", 32'(motion_cnt_vld), 32'(e_vld[cyc]));
      chk("motion_cnt", 32'(motion_cnt), 32'(mc_exp));
      if (l_dset[cyc]) chk("lit_post_data", 32'(post_data), 32'(l_data[cyc]));
      if (l_cset[cyc]) begin
        chk("lit_motion_cnt", 32'(motion_cnt), 32'(l_cnt[cyc]));
        chk("lit_motion_cnt_vld", 32'(motion_cnt_vld), 32'd1);
      end
    end
  end

  initial begin
    int n;
    logic [W-1:0] c;
    logic [W-1:0] r;
    cfg_thresh = 8'd50;
    cfg_mode   = 2'd0;
    do_reset(1'b0, 4);
    idle(3);

    // First frame after reset is blanked and counts 0
    frame_begin();
    repeat (10) px_lit(rep(200), rep(0), '0);
    frame_end(1'b1, 0);

    // Mode 0, threshold 50
    frame_begin();
    px_lit(rep(100), rep(40), rep(60));
    px_lit(rep(40), rep(100), rep(60));
    px_lit(rep(90), rep(40), '0);
    frame_end(1'b1, 2);

    // Mode 1, per-channel decision: diffs {5,20,0} on ch0..ch2
    cfg_thresh = 8'd10;
    cfg_mode   = 2'd1;
    frame_begin();
    px_lit({8'd7, 8'd20, 8'd5}, {8'd7, 8'd0, 8'd0}, 24'h00FF00);
    frame_end(1'b1, 1);

    // Shadow threshold: mid-frame change has no effect until next frame
    cfg_thresh = 8'd50;
    cfg_mode   = 2'd0;
    frame_begin();
    px_lit(rep(100), rep(40), rep(60));
    cfg_thresh = 8'd0;
    px_lit(rep(60), rep(40), '0);
    frame_end(1'b1, 1);
    frame_begin();
    px_lit(rep(60), rep(40), rep(20));
    px_lit(rep(9), rep(9), '0);
    frame_end(1'b1, 1);

    // Saturation at 15, then restart from 0
    cfg_mode = 2'd2;
    frame_begin();
    for (int i = 0; i < 20; i++) px_lit(rep(5 + i), rep(0), rep(5 + i));
    frame_end(1'b1, 15);
    frame_begin();
    repeat (3) px(rep(77), rep(7));
    frame_end(1'b1, 3);

    // Frame without valid pixels
    frame_begin();
    repeat (3) gap();
    frame_end(1'b1, 0);

    // Randomised frames with random config and mid-frame config noise
    for (int f = 0; f < 10; f++) begin
      cfg_thresh = DW'($urandom_range(0, 255));
      cfg_mode   = 2'($urandom_range(0, 3));
      frame_begin();
      n = $urandom_range(10, 30);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 9) == 0) cfg_thresh = DW'($urandom);
        if ($urandom_range(0, 9) == 0) cfg_mode = 2'($urandom);
        if ($urandom_range(0, 3) == 0) gap();
        else begin
          c = W'($urandom);
          r = W'($urandom);
          px(c, r);
        end
      end
      frame_end(1'b0, 0);
    end

    // Reset mid-frame after 7 motion pixels
    cfg_thresh = 8'd0;
    cfg_mode   = 2'd0;
    frame_begin();
    repeat (7) px(rep(30), rep(10));
    do_reset(1'b0, 3);
    idle(3);
    frame_begin();
    repeat (5) px_lit(rep(30), rep(10), '0);
    frame_end(1'b1, 0);
    frame_begin();
    repeat (4) px_lit(rep(30), rep(10), rep(20));
    frame_end(1'b1, 4);

    // Reset released while vsync is high: partial frame is suppressed
    frame_begin();
    repeat (3) px(rep(90), rep(10));
    do_reset(1'b1, 3);
    repeat (4) px_lit(rep(90), rep(10), '0);
    frame_end(1'b1, 0);
    cfg_thresh = 8'd100;
    frame_begin();
    for (int i = 0; i < 12; i++) begin
      c = W'($urandom);
      r = W'($urandom);
      px(c, r);
    end
    frame_end(1'b0, 0);

    idle(6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
